// File: rtl/inversor_pkg.sv
// inversor_pkg
// Shared definitions for the inversor_pipeline slice: the per-word transform
// selector carried on in_mode.
package inversor_pkg;

    // Transform applied to a word as it enters the pipeline
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NEG  = 2'b11
    } mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/inversor_pipeline_pipe_stage.sv
// pipe_stage
// One register slot of the elastic pipeline: a valid flag plus a data word.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load        - stage takes a new {valid, data} from upstream this edge
//   prev_valid  - upstream valid (producer valid for the first stage)
//   prev_data   - upstream data word
//   valid, data - registered contents of this stage
module pipe_stage
    import inversor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data is only overwritten when a real word arrives, so an empty stage
    // keeps its old value and a bubble never disturbs a held output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/inversor_pipeline.sv
// inversor_pipeline
// Registered, elastic replacement for the combinational inverter. Each
// accepted word is transformed (pass / invert / XOR mask / negate) and then
// travels through STAGES register slots with valid/ready flow control.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_valid/in_ready    - producer handshake
//   in_data, in_mode     - word and its transform selector
//   mask                 - XOR mask used when in_mode selects MODE_XOR
//   out_valid/out_ready  - consumer handshake
//   out_data             - transformed word from the last stage
//   count_clr            - synchronous clear of out_count
//   out_count            - completed output transfers, wrapping
module inversor_pipeline
    import inversor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             count_clr,
    output logic [CNT_W-1:0] out_count
);

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [WIDTH-1:0] a,
        input mode_t            mode,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH-1:0] y;
        case (mode)
            MODE_PASS: y = a;
            MODE_INV:  y = ~a;
            MODE_XOR:  y = a ^ m;
            MODE_NEG:  y = ~a + WIDTH'(1);
            default:   y = a;
        endcase
        return y;
    endfunction

    logic [WIDTH-1:0] xform_data;
    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [STAGES];
    logic [STAGES:0]   ready_chain;
    logic              out_xfer;

    assign xform_data = apply_mode(in_data, mode_t'(in_mode), mask);

    // Ready ripples backwards from the consumer: a stage can load when it is
    // empty or when the stage after it is loading too, so a full pipeline
    // still moves one word per cycle while out_ready is high.
    always_comb begin
        ready_chain         = '0;
        ready_chain[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_chain[k] = !stage_valid[k] || ready_chain[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = xform_data;
        end else begin : g_rest
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .load       (ready_chain[k]),
            .prev_valid (up_valid),
            .prev_data  (up_data),
            .valid      (stage_valid[k]),
            .data       (stage_data[k])
        );
    end

    assign in_ready  = ready_chain[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign out_xfer  = out_valid && out_ready;

    // A clear beats a coinciding transfer, which is then not counted
    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            out_count <= '0;
        end else if (out_xfer) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inversor_pipeline.sv
// tb_inversor_pipeline
// Self-checking bench for inversor_pipeline (WIDTH=4, STAGES=2, CNT_W=4).
// A queue-based reference model tracks the words in flight and the time
// each becomes visible at the output; every cycle the DUT handshake,
// data and counter are compared against it.
module tb_inversor_pipeline;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             count_clr;
    logic [CNT_W-1:0] out_count;

    inversor_pipeline #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count_clr (count_clr),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int avail;
    } word_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [1:0]       mode;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] y;
    } vec_t;

    word_t model_q[$];
    int    model_cnt = 0;
    int    edges = 0;
    int    total_checks = 0;
    int    passed_checks = 0;

    // Transform from the arithmetic definition of each mode
    function automatic int ref_transform(input int a, input int mode, input int m);
        int full;
        full = 1 << WIDTH;
        case (mode)
            0:       return a;
            1:       return (full - 1) - a;
            2:       return a ^ m;
            default: return (full - a) % full;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end else begin
            passed_checks++;
        end
    endtask

    function automatic bit model_out_valid();
        return model_q.size() > 0 && edges >= model_q[0].avail;
    endfunction

    // One clock cycle: compare the DUT against the model for the current
    // inputs, then advance the model and the DUT across one rising edge.
    task automatic apply_stimulus();
        bit exp_ov, exp_ir, in_x, out_x;
        word_t w;
        #1;
        exp_ov = model_out_valid();
        exp_ir = (model_q.size() < STAGES) || (exp_ov && out_ready);
        check_output("out_valid", 32'(out_valid), 32'(exp_ov));
        check_output("in_ready", 32'(in_ready), 32'(exp_ir));
        check_output("out_count", 32'(out_count), 32'(model_cnt));
        if (exp_ov) begin
            check_output("out_data", 32'(out_data), 32'(model_q[0].data));
        end
        in_x  = in_valid && exp_ir;
        out_x = exp_ov && out_ready;
        if (reset) begin
            model_q.delete();
            model_cnt = 0;
        end else begin
            if (out_x) void'(model_q.pop_front());
            if (in_x) begin
                w.data  = ref_transform(int'(in_data), int'(in_mode), int'(mask));
                w.avail = edges + STAGES;
                model_q.push_back(w);
            end
            if (count_clr) model_cnt = 0;
            else if (out_x) model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        count_clr = 1'b0;
        for (int i = 0; i < 20 && model_q.size() > 0; i++) apply_stimulus();
        check_output("drain_empty", 32'(model_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        apply_stimulus();
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{4'b0101, 2'b00, 4'b0000, 4'b0101};
        vecs[1] = '{4'b0101, 2'b10, 4'b0011, 4'b0110};
        vecs[2] = '{4'b0001, 2'b11, 4'b0000, 4'b1111};
        vecs[3] = '{4'b1000, 2'b11, 4'b0000, 4'b1000};
        vecs[4] = '{4'b0000, 2'b11, 4'b0000, 4'b0000};
        vecs[5] = '{4'b0000, 2'b01, 4'b0000, 4'b1111};
        vecs[6] = '{4'b1100, 2'b10, 4'b1010, 4'b0110};

        reset = 1'b1; in_valid = 1'b1; in_data = 4'h5; in_mode = 2'b01;
        mask = '0; out_ready = 1'b1; count_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with in_valid asserted: nothing may enter
        for (int i = 0; i < 3; i++) apply_stimulus();
        #1;
        check_output("reset_out_data", 32'(out_data), 32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_count", 32'(out_count), 32'd0);

        // First word after release: invisible after one edge, visible after two
        reset = 1'b0; in_valid = 1'b1; in_data = 4'b0011; in_mode = 2'b01;
        apply_stimulus();
        in_valid = 1'b0;
        apply_stimulus();
        #1;
        check_output("latency_valid", 32'(out_valid), 32'd1);
        check_output("latency_data", 32'(out_data), 32'b1100);
        drain();

        // Table of single words, each checked at the output two edges later
        do_reset();
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_data = vecs[i].a; in_mode = vecs[i].mode; mask = vecs[i].m;
            apply_stimulus();
            in_valid = 1'b0;
            apply_stimulus();
            #1;
            check_output("table_valid", 32'(out_valid), 32'd1);
            check_output("table_data", 32'(out_data), 32'(vecs[i].y));
        end
        drain();

        // Exhaustive invert at full rate; 16 transfers wrap a 4-bit counter
        do_reset();
        out_ready = 1'b1; in_mode = 2'b01;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            apply_stimulus();
        end
        drain();
        #1;
        check_output("invert_count_wrap", 32'(out_count), 32'd0);

        // Seventeen transfers leave the counter at 1
        do_reset();
        in_mode = 2'b00;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            apply_stimulus();
        end
        drain();
        #1;
        check_output("count_17", 32'(out_count), 32'd1);

        // Backpressure: two words fill the pipe, third is refused
        do_reset();
        out_ready = 1'b0; in_mode = 2'b01; in_valid = 1'b1;
        in_data = 4'b0001; apply_stimulus();
        in_data = 4'b0010; apply_stimulus();
        in_data = 4'b0011; apply_stimulus();
        apply_stimulus();
        #1;
        check_output("bp_in_ready", 32'(in_ready), 32'd0);
        check_output("bp_hold_data", 32'(out_data), 32'b1110);
        out_ready = 1'b1;
        apply_stimulus();
        drain();
        #1;
        check_output("bp_count", 32'(out_count), 32'd3);

        // Clear coinciding with a transfer wins
        do_reset();
        in_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 1);
            apply_stimulus();
        end
        in_valid = 1'b0;
        apply_stimulus();
        count_clr = 1'b1;
        apply_stimulus();
        count_clr = 1'b0;
        #1;
        check_output("clr_with_xfer", 32'(out_count), 32'd0);
        drain();

        // Reset in the middle of a stall discards everything in flight
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            in_data = 4'(i + 7);
            apply_stimulus();
        end
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check_output("rst_stall_valid", 32'(out_valid), 32'd0);
        check_output("rst_stall_ready", 32'(in_ready), 32'd1);
        check_output("rst_stall_count", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            in_mode   = 2'($urandom);
            mask      = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            count_clr = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            apply_stimulus();
        end
        reset = 1'b0;
        drain();

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
